mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads and stores onto a multi-cycle
// data memory. Issues a one-cycle request strobe, stalls the pipeline until
// the memory answers, captures load data and handles halt drain and fatal
// errors (misaligned or conflicting request, memory fault, response timeout).
module mem_access_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              halt,
   input  logic              mem_done,
   input  logic              mem_err,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              access_done,
   output logic              pipe_stall,
   output logic              halted,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      HALTED,
      ERROR
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                access_done_q, access_done_d;
   logic                halted_q, halted_d;
   logic                err_q, err_d;
   logic                req;

   assign req = mem_read | mem_write;

   // Next-state logic: accepts and checks requests in IDLE, tracks the
   // memory handshake and wait budget, and derives the registered outputs
   // from the state being entered.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_wr_d      = mem_wr_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      rd_data_d     = rd_data_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req) begin
               if ((mem_read && mem_write) || addr[0]) begin
                  state_d = ERROR;
               end else begin
                  mem_wr_d      = mem_write;
                  mem_addr_d    = addr;
                  mem_wr_data_d = wr_data;
                  state_d       = ISSUE;
               end
            end else if (halt) begin
               state_d = HALTED;
            end
         end
         ISSUE, WAIT: begin
            if (mem_done) begin
               cnt_d = '0;
               if (mem_err) begin
                  state_d = ERROR;
               end else begin
                  if (!mem_wr_q) begin
                     rd_data_d = mem_rd_data;
                  end
                  state_d = DONE;
               end
            end else if (state_q == ISSUE) begin
               cnt_d   = '0;
               state_d = WAIT;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TIMEOUT_CNT) begin
                  state_d = ERROR;
               end
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = halt ? HALTED : IDLE;
         end
         HALTED: state_d = HALTED;
         ERROR:  state_d = ERROR;
         default: state_d = IDLE;
      endcase

      mem_en_d      = (state_d == ISSUE);
      access_done_d = (state_d == DONE);
      halted_d      = (state_d == HALTED);
      err_d         = (state_d == ERROR);
   end

   // State and output registers with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         mem_en_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         rd_data_q     <= '0;
         access_done_q <= 1'b0;
         halted_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_en_q      <= mem_en_d;
         mem_wr_q      <= mem_wr_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         rd_data_q     <= rd_data_d;
         access_done_q <= access_done_d;
         halted_q      <= halted_d;
         err_q         <= err_d;
      end
   end

   // Stall is combinational so a new request freezes the pipeline in the very
   // cycle it is seen; only the DONE cycle lets the pipeline advance.
   always_comb begin
      pipe_stall = 1'b1;
      case (state_q)
         IDLE:    pipe_stall = req;
         DONE:    pipe_stall = 1'b0;
         default: pipe_stall = 1'b1;
      endcase
   end

   assign mem_en      = mem_en_q;
   assign mem_wr      = mem_wr_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_data = mem_wr_data_q;
   assign rd_data     = rd_data_q;
   assign access_done = access_done_q;
   assign halted      = halted_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: transaction-level bench for mem_access_ctrl. Each
// transaction holds a request, answers it after a chosen number of wait
// cycles and compares the observed handshake against expectations taken from
// a hand-written table or from a transaction-level reference model.
module tb_mem_access_ctrl;

   localparam int TIMEOUT = 31;
   localparam int MAX_CYCLES = 60;

   logic        clk = 1'b0;
   logic        rst;
   logic        memRead, memWrite, halt, memDone, memErr;
   logic [15:0] addr, wrData, memRdData;
   logic        memEn, memWr, accessDone, pipeStall, halted, err;
   logic [15:0] memAddr, memWrData, rdData;

   int          total = 0;
   int          bad = 0;
   logic [15:0] modelRd;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          waits;
      logic        merr;
      logic [15:0] rdata;
      logic        expErr;
      int          expEnd;
      logic [15:0] expRd;
   } vec_t;

   vec_t vecs[10];

   mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_read    (memRead),
      .mem_write   (memWrite),
      .addr        (addr),
      .wr_data     (wrData),
      .halt        (halt),
      .mem_done    (memDone),
      .mem_err     (memErr),
      .mem_rd_data (memRdData),
      .mem_en      (memEn),
      .mem_wr      (memWr),
      .mem_addr    (memAddr),
      .mem_wr_data (memWrData),
      .rd_data     (rdData),
      .access_done (accessDone),
      .pipe_stall  (pipeStall),
      .halted      (halted),
      .err         (err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case a wait is never satisfied.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   task automatic idleInputs();
      memRead   = 1'b0;
      memWrite  = 1'b0;
      addr      = 16'h0;
      wrData    = 16'h0;
      halt      = 1'b0;
      memDone   = 1'b0;
      memErr    = 1'b0;
      memRdData = 16'h0;
   endtask

   // Pulses reset for one edge and checks every output returned to zero.
   task automatic doReset();
      rst = 1'b1;
      idleInputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelRd = 16'h0;
      checkOutput("reset_outputs",
                  {memEn, memWr, memAddr, memWrData, rdData, accessDone, pipeStall, halted, err},
                  64'h0);
   endtask

   // Transaction-level reference: outcome, completion cycle and load data.
   function automatic vec_t modelTxn(input vec_t v, input logic [15:0] curRd);
      vec_t r;
      r = v;
      r.expRd = curRd;
      if ((v.rd && v.wr) || v.addr[0]) begin
         r.expErr = 1'b1;
         r.expEnd = 1;
      end else if (v.waits > TIMEOUT) begin
         r.expErr = 1'b1;
         r.expEnd = TIMEOUT + 2;
      end else if (v.merr) begin
         r.expErr = 1'b1;
         r.expEnd = 2 + v.waits;
      end else begin
         r.expErr = 1'b0;
         r.expEnd = 2 + v.waits;
         if (v.rd) r.expRd = v.rdata;
      end
      return r;
   endfunction

   // Drives one request until completion or error; starts just after a
   // rising edge and returns at the falling edge of the final cycle.
   task automatic applyStimulus(input vec_t v, input int haltFrom, output logic sawErr);
      int   c;
      int   enCount;
      int   doneCount;
      int   stallCount;
      logic finished;
      c = 0;
      enCount = 0;
      doneCount = 0;
      stallCount = 0;
      finished = 1'b0;
      while (!finished) begin
         memRead   = v.rd;
         memWrite  = v.wr;
         addr      = v.addr;
         wrData    = v.wdata;
         halt      = (haltFrom >= 0) && (c >= haltFrom);
         memDone   = (c == 1 + v.waits);
         memErr    = memDone ? v.merr : 1'($urandom);
         memRdData = memDone ? v.rdata : 16'($urandom);
         @(negedge clk);
         if (memEn) begin
            enCount++;
            checkOutput("issue_cycle", c, 1);
            checkOutput("issue_addr", memAddr, v.addr);
            checkOutput("issue_wr", memWr, v.wr);
            if (v.wr) checkOutput("issue_wdata", memWrData, v.wdata);
         end
         if (accessDone) doneCount++;
         if (pipeStall) stallCount++;
         if (accessDone || err || c >= MAX_CYCLES) begin
            finished = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            c++;
         end
      end
      checkOutput("end_cycle", c, v.expEnd);
      checkOutput("err_flag", err, v.expErr);
      checkOutput("access_done_count", doneCount, v.expErr ? 0 : 1);
      checkOutput("mem_en_count", enCount, (v.expErr && v.expEnd == 1) ? 0 : 1);
      checkOutput("stall_cycles", stallCount, v.expErr ? v.expEnd + 1 : v.expEnd);
      if (!v.expErr) checkOutput("rd_data", rdData, v.expRd);
      sawErr = err;
   endtask

   initial begin
      logic sawErr;
      vec_t v;

      // rd wr addr wdata waits merr rdata | expErr expEnd expRd
      vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000,  3, 1'b0, 16'hBEEF, 1'b0,  5, 16'hBEEF};
      vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234,  0, 1'b0, 16'hDEAD, 1'b0,  2, 16'hBEEF};
      vecs[2] = '{1'b1, 1'b0, 16'h0002, 16'h0000,  0, 1'b0, 16'h5A5A, 1'b0,  2, 16'h5A5A};
      vecs[3] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 31, 1'b0, 16'h1111, 1'b0, 33, 16'h1111};
      vecs[4] = '{1'b1, 1'b0, 16'h0003, 16'h0000,  0, 1'b0, 16'h2222, 1'b1,  1, 16'h0000};
      vecs[5] = '{1'b1, 1'b1, 16'h0004, 16'h0000,  0, 1'b0, 16'h3333, 1'b1,  1, 16'h0000};
      vecs[6] = '{1'b1, 1'b0, 16'h0006, 16'h0000, 32, 1'b0, 16'h4444, 1'b1, 33, 16'h0000};
      vecs[7] = '{1'b0, 1'b1, 16'h0008, 16'h7777,  2, 1'b1, 16'h5555, 1'b1,  4, 16'h0000};
      vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000,  1, 1'b0, 16'hCAFE, 1'b0,  3, 16'hCAFE};
      vecs[9] = '{1'b1, 1'b0, 16'h0002, 16'h0000,  0, 1'b0, 16'h0F0F, 1'b0,  2, 16'h0F0F};

      idleInputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      doReset();

      // Table-driven transactions, back-to-back unless an error forces reset.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i], -1, sawErr);
         @(posedge clk);
         #1;
         if (!vecs[i].expErr) modelRd = vecs[i].expRd;
         if (sawErr) doReset();
      end

      // Randomised transactions against the reference model.
      for (int i = 0; i < 40; i++) begin
         int r;
         v.rd    = 1'($urandom_range(0, 1));
         v.wr    = !v.rd;
         if ($urandom_range(0, 9) == 0) begin
            v.rd = 1'b1;
            v.wr = 1'b1;
         end
         v.addr  = 16'($urandom) & 16'hFFFE;
         if ($urandom_range(0, 7) == 0) v.addr[0] = 1'b1;
         v.wdata = 16'($urandom);
         v.rdata = 16'($urandom);
         r = $urandom_range(0, 15);
         v.waits = (r < 13) ? $urandom_range(0, 4) : ((r < 15) ? TIMEOUT : TIMEOUT + 1);
         v.merr  = ($urandom_range(0, 9) == 0);
         v = modelTxn(v, modelRd);
         applyStimulus(v, -1, sawErr);
         @(posedge clk);
         #1;
         if (!v.expErr) modelRd = v.expRd;
         if (sawErr) doReset();
      end

      // Halt raised while waiting: the access finishes, then the core halts.
      v = '{1'b1, 1'b0, 16'h0008, 16'h0000, 3, 1'b0, 16'hA5A5, 1'b0, 5, 16'hA5A5};
      applyStimulus(v, 2, sawErr);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("halt_wait_halted", halted, 1'b1);
      checkOutput("halt_wait_stall", pipeStall, 1'b1);
      begin
         int enSeen;
         enSeen = 0;
         halt = 1'b0;
         memRead = 1'b1;
         addr = 16'h0040;
         for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (memEn) enSeen++;
         end
         checkOutput("halted_no_issue", enSeen, 0);
         checkOutput("halted_sticky", halted, 1'b1);
      end
      @(posedge clk);
      #1;
      doReset();

      // Request and halt together: request wins, halt taken in DONE.
      v = '{1'b0, 1'b1, 16'h0030, 16'h9999, 0, 1'b0, 16'h0000, 1'b0, 2, 16'h0000};
      applyStimulus(v, 0, sawErr);
      @(posedge clk);
      #1;
      idleInputs();
      @(negedge clk);
      checkOutput("req_halt_halted", halted, 1'b1);
      @(posedge clk);
      #1;
      doReset();

      // Halt with no request: stall stays low that cycle, then halted.
      halt = 1'b1;
      @(negedge clk);
      checkOutput("idle_halt_stall", pipeStall, 1'b0);
      @(posedge clk);
      #1;
      halt = 1'b0;
      @(negedge clk);
      checkOutput("idle_halt_halted", halted, 1'b1);
      checkOutput("idle_halt_stall_after", pipeStall, 1'b1);
      @(posedge clk);
      #1;
      doReset();

      // Reset while waiting abandons the access; a late mem_done is ignored.
      memRead = 1'b1;
      addr = 16'h0050;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
      end
      doReset();
      memDone = 1'b1;
      memRdData = 16'hFFFF;
      @(negedge clk);
      checkOutput("late_done_stall", pipeStall, 1'b0);
      @(posedge clk);
      #1;
      memDone = 1'b0;
      @(negedge clk);
      checkOutput("late_done_ignored", {accessDone, memEn, rdData}, 18'h0);
      @(posedge clk);
      #1;
      v = '{1'b1, 1'b0, 16'h0060, 16'h0000, 1, 1'b0, 16'h1357, 1'b0, 3, 16'h1357};
      applyStimulus(v, -1, sawErr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
